// File: rtl/blue_motion_ctrl.sv
// ---------------------------------------------------------------------------
// blue_motion_ctrl
// Motion/physics controller for the blue character (47x41 sprite). Turns the
// player keys and the registered collision flags into the sprite's top-left
// position, updated once per internal physics tick.
//
// Ports
//   clk           system clock
//   rst           asynchronous active-high reset
//   key_left      level, move left
//   key_right     level, move right
//   key_jump      level, jump (rising edges only)
//   is_Collision  [0]=down [1]=up [2]=right [3]=left
//   x_blue        sprite x (10b unsigned)
//   y_blue        sprite y (9b unsigned)
//   on_ground     1 while in GROUND
//   tick          1-cycle pulse on each physics update cycle
//
// Build option
//   DOUBLE_JUMP_EN  allows one extra jump per airborne period.
//
// state   | meaning
// GROUND  | standing on a surface or the screen floor
// RISE    | moving up, speed decays by GRAVITY each tick
// FALL    | moving down, speed grows by GRAVITY up to VMAX
// ---------------------------------------------------------------------------
module blue_motion_ctrl #(
    parameter int unsigned TICK_DIV = 833333,
    parameter int unsigned X_INIT   = 40,
    parameter int unsigned Y_INIT   = 400,
    parameter int unsigned X_STEP   = 2,
    parameter int unsigned JUMP_V   = 8,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned VMAX     = 8,
    parameter int unsigned X_MAX    = 593,
    parameter int unsigned Y_MAX    = 439
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    input  logic [3:0] is_Collision,
    output logic [9:0] x_blue,
    output logic [8:0] y_blue,
    output logic       on_ground,
    output logic       tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic signed [10:0] XS_S   = 11'(X_STEP);
    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
    localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);
    localparam logic signed [10:0] G_S    = 11'(GRAVITY);
    localparam logic signed [10:0] VMAX_S = 11'(VMAX);

    typedef enum logic [1:0] {ST_GROUND, ST_RISE, ST_FALL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    vy_q, vy_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic          jump_req_q, jump_req_d;
    logic          jump_prev_q, jump_prev_d;
`ifdef DOUBLE_JUMP_EN
    logic          air_jump_used_q, air_jump_used_d;
`endif

    logic        tick_w;
    logic signed [10:0] x_ext, y_ext, vy_ext;
    logic signed [10:0] x_dec, x_inc, y_up, y_dn, vy_dec, vy_inc;

    always_comb begin
        tick_w      = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d       = tick_w ? '0 : cnt_q + 1'b1;
        jump_prev_d = key_jump;
        // A new edge on the tick cycle survives the tick's clear.
        jump_req_d  = (jump_req_q && !tick_w) || (key_jump && !jump_prev_q);

        x_d     = x_q;
        y_d     = y_q;
        vy_d    = vy_q;
        state_d = state_q;
`ifdef DOUBLE_JUMP_EN
        air_jump_used_d = air_jump_used_q;
`endif

        // Widened signed arithmetic so clamps see underflow/overflow.
        x_ext  = $signed({1'b0, x_q});
        y_ext  = $signed({2'b00, y_q});
        vy_ext = $signed({7'b0, vy_q});
        x_dec  = x_ext - XS_S;
        x_inc  = x_ext + XS_S;
        y_up   = y_ext - vy_ext;
        y_dn   = y_ext + vy_ext;
        vy_dec = vy_ext - G_S;
        vy_inc = vy_ext + G_S;

        if (tick_w) begin
            if (key_left && !key_right && !is_Collision[3]) begin
                x_d = (x_dec < 0) ? 10'd0 : x_dec[9:0];
            end else if (key_right && !key_left && !is_Collision[2]) begin
                x_d = (x_inc > XMAX_S) ? 10'(X_MAX) : x_inc[9:0];
            end

            case (state_q)
                ST_GROUND: begin
                    if (!is_Collision[0] && (y_q != 9'(Y_MAX))) begin
                        state_d = ST_FALL;
                        vy_d    = 4'd0;
                    end else if (jump_req_q) begin
                        state_d = ST_RISE;
                        vy_d    = 4'(JUMP_V);
                    end
                end
                ST_RISE: begin
                    if (is_Collision[1]) begin
                        state_d = ST_FALL;
                        vy_d    = 4'd0;
                    end
`ifdef DOUBLE_JUMP_EN
                    else if (jump_req_q && !air_jump_used_q) begin
                        vy_d            = 4'(JUMP_V);
                        air_jump_used_d = 1'b1;
                    end
`endif
                    else begin
                        y_d = (y_up <= 0) ? 9'd0 : y_up[8:0];
                        if ((vy_dec <= 0) || (y_up <= 0)) begin
                            state_d = ST_FALL;
                            vy_d    = 4'd0;
                        end else begin
                            vy_d = vy_dec[3:0];
                        end
                    end
                end
                default: begin
                    if (is_Collision[0]) begin
                        state_d = ST_GROUND;
                        vy_d    = 4'd0;
`ifdef DOUBLE_JUMP_EN
                        air_jump_used_d = 1'b0;
`endif
                    end
`ifdef DOUBLE_JUMP_EN
                    else if (jump_req_q && !air_jump_used_q) begin
                        state_d         = ST_RISE;
                        vy_d            = 4'(JUMP_V);
                        air_jump_used_d = 1'b1;
                    end
`endif
                    else begin
                        y_d = (y_dn >= YMAX_S) ? 9'(Y_MAX) : y_dn[8:0];
                        if (y_dn >= YMAX_S) begin
                            state_d = ST_GROUND;
                            vy_d    = 4'd0;
`ifdef DOUBLE_JUMP_EN
                            air_jump_used_d = 1'b0;
`endif
                        end else begin
                            vy_d = (vy_inc > VMAX_S) ? 4'(VMAX) : vy_inc[3:0];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FALL;
            cnt_q       <= '0;
            vy_q        <= 4'd0;
            x_q         <= 10'(X_INIT);
            y_q         <= 9'(Y_INIT);
            jump_req_q  <= 1'b0;
            jump_prev_q <= 1'b0;
`ifdef DOUBLE_JUMP_EN
            air_jump_used_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vy_q        <= vy_d;
            x_q         <= x_d;
            y_q         <= y_d;
            jump_req_q  <= jump_req_d;
            jump_prev_q <= jump_prev_d;
`ifdef DOUBLE_JUMP_EN
            air_jump_used_q <= air_jump_used_d;
`endif
        end
    end

    assign x_blue    = x_q;
    assign y_blue    = y_q;
    assign on_ground = (state_q == ST_GROUND);
    assign tick      = tick_w;

endmodule

// File: tb/tb_blue_motion_ctrl.sv
module tb_blue_motion_ctrl;

    localparam int TD = 4;
    localparam int S_GND = 0, S_RISE = 1, S_FALL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0;
    logic [3:0] coll = 4'h0;
    logic [9:0] x_blue;
    logic [8:0] y_blue;
    logic       on_ground, tick;

    always #5 clk = ~clk;

    blue_motion_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .key_left(key_left), .key_right(key_right),
        .key_jump(key_jump), .is_Collision(coll), .x_blue(x_blue),
        .y_blue(y_blue), .on_ground(on_ground), .tick(tick)
    );

`ifdef DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
`else
    localparam bit DJ = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position/speed as plain integers, updated per tick.
    int m_x, m_y, m_vy, m_st, m_cnt;
    bit m_jreq, m_jprev, m_used;

    function automatic void m_reset();
        m_x = 40; m_y = 400; m_vy = 0; m_st = S_FALL; m_cnt = 0;
        m_jreq = 0; m_jprev = 0; m_used = 0;
    endfunction

    function automatic void m_land();
        m_st = S_GND; m_vy = 0; m_used = 0;
    endfunction

    function automatic void m_physics();
        int t;
        if (key_left && !key_right && !coll[3]) m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
        else if (key_right && !key_left && !coll[2]) m_x = (m_x + 2 > 593) ? 593 : m_x + 2;
        if (m_st == S_GND) begin
            if (!coll[0] && m_y != 439) begin m_st = S_FALL; m_vy = 0; end
            else if (m_jreq) begin m_st = S_RISE; m_vy = 8; end
        end else if (m_st == S_RISE) begin
            if (coll[1]) begin m_st = S_FALL; m_vy = 0; end
            else if (DJ && m_jreq && !m_used) begin m_vy = 8; m_used = 1; end
            else begin
                t = m_y - m_vy;
                m_y = (t < 0) ? 0 : t;
                if (m_vy - 1 <= 0 || m_y == 0) begin m_st = S_FALL; m_vy = 0; end
                else m_vy = m_vy - 1;
            end
        end else begin
            if (coll[0]) m_land();
            else if (DJ && m_jreq && !m_used) begin m_st = S_RISE; m_vy = 8; m_used = 1; end
            else begin
                t = m_y + m_vy;
                m_y = (t > 439) ? 439 : t;
                if (m_y == 439) m_land();
                else m_vy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("x", 32'(x_blue), m_x);
        chk("y", 32'(y_blue), m_y);
        chk("on_ground", 32'(on_ground), 32'(m_st == S_GND));
        chk("tick", 32'(tick), 32'(m_cnt == TD - 1));
    endtask

    task automatic cyc();
        bit was_tick;
        @(posedge clk);
        if (rst) m_reset();
        else begin
            was_tick = (m_cnt == TD - 1);
            if (was_tick) m_physics();
            m_jreq  = (m_jreq && !was_tick) || (key_jump && !m_jprev);
            m_jprev = key_jump;
            m_cnt   = (m_cnt + 1) % TD;
        end
        #1;
        check_all();
    endtask

    task automatic run_ticks(input int n);
        int k = 0;
        while (k < n) begin
            if (m_cnt == TD - 1) k++;
            cyc();
        end
    endtask

    task automatic pulse_jump();
        key_jump = 1'b1; cyc();
        key_jump = 1'b0; cyc();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1 m_reset();
        check_all();
        cyc(); cyc();
        rst = 1'b0;
    endtask

    int y0;

    initial begin
        m_reset();
        repeat (3) cyc();
        rst = 1'b0;
        repeat (10) cyc();

        // Reset mid-run, then free fall from Y_INIT
        async_reset();
        chk("rst_x", 32'(x_blue), 40);
        chk("rst_y", 32'(y_blue), 400);
        run_ticks(1); chk("fall_y0", 32'(y_blue), 400);
        run_ticks(1); chk("fall_y1", 32'(y_blue), 401);
        run_ticks(1); chk("fall_y2", 32'(y_blue), 403);
        run_ticks(1); chk("fall_y3", 32'(y_blue), 406);

        // Landing on a platform
        coll = 4'b0001;
        run_ticks(1);
        chk("land_y", 32'(y_blue), 406);
        chk("land_og", 32'(on_ground), 1);

        // Jump from the platform: 8 rising ticks, total -36
        pulse_jump();
        run_ticks(1);
        chk("jump_hold_y", 32'(y_blue), 406);
        coll = 4'b0000;
        run_ticks(1); chk("rise_y1", 32'(y_blue), 398);
        run_ticks(7); chk("rise_y8", 32'(y_blue), 370);
        chk("rise_air", 32'(on_ground), 0);

        // Fall to the screen floor
        run_ticks(40);
        chk("floor_y", 32'(y_blue), 439);
        chk("floor_og", 32'(on_ground), 1);

        // Head bump while rising
        pulse_jump();
        run_ticks(3);
        coll = 4'b0010;
        y0 = m_y;
        run_ticks(1);
        chk("bump_y", 32'(y_blue), y0);
        coll = 4'b0000;
        run_ticks(1);
        chk("bump_fall_y", 32'(y_blue), y0);

        // Held jump key yields one jump only
        key_jump = 1'b1;
        run_ticks(45);
        chk("held_og", 32'(on_ground), 1);
        key_jump = 1'b0;
        run_ticks(2);

        // Horizontal: blocked, right edge, left edge, both keys
        coll = 4'b0100; key_right = 1'b1;
        run_ticks(3);
        chk("block_r", 32'(x_blue), 40);
        coll = 4'b0000;
        run_ticks(300);
        chk("x_max", 32'(x_blue), 593);
        key_right = 1'b0; key_left = 1'b1;
        run_ticks(300);
        chk("x_min", 32'(x_blue), 0);
        key_right = 1'b1;
        run_ticks(3);
        chk("both_keys", 32'(x_blue), 0);
        key_right = 1'b0; key_left = 1'b0;

        // Air jump from FALL
        pulse_jump();
        run_ticks(1);
        run_ticks(8);
        run_ticks(2);
        chk("air_y0", 32'(y_blue), 404);
        pulse_jump();
        run_ticks(1);
        chk("air_y1", 32'(y_blue), DJ ? 404 : 406);
        run_ticks(1);
        chk("air_y2", 32'(y_blue), DJ ? 396 : 409);
        pulse_jump();
        run_ticks(1);
        chk("air_y3", 32'(y_blue), DJ ? 389 : 413);
        run_ticks(40);

        // Randomized traffic against the model
        for (int i = 0; i < 1600; i++) begin
            key_left  = ($urandom_range(0, 3) == 0);
            key_right = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) key_jump = ~key_jump;
            coll = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if (i == 800) async_reset();
            else cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
